// File: rtl/cpu_dmem.sv
// -----------------------------------------------------------------------------
// cpu_dmem -- data-memory responder on the core's load/store port.
//
// It accepts at most one request per cycle from the memory-access stage and
// never stalls. Stores write byte, halfword or word data. Only the byte lanes
// covered by the access are changed.
//
// A load reads the addressed word at the request edge. Lane selection and
// sign/zero extension are done combinationally from registered state, so
// ram_dout is valid one cycle after the request. ram_dout keeps the last load
// result until another load arrives.
//
// Illegal funct3 codes are reported as errors. Misaligned accesses are also
// errors unless the optional feature is enabled. Each error pulses err for one
// cycle and bumps the saturating err_cnt.
//
// Optional feature: `DMEM_MISALIGN_EN
//   Undefined (default): one word-wide bank. A misaligned halfword/word access
//     does not write, a misaligned load returns 0, and both count as errors.
//   Defined: storage is split into even-word and odd-word banks. A misaligned
//     access touches two adjacent words in one cycle, wrapping from the top
//     word to word 0. It is not an error.
//
// Parameters
//   ADDR_W    word-address width; capacity is 2**ADDR_W words
//
// Ports
//   clk       in   1   system clock, all state on the rising edge
//   rst       in   1   synchronous active-high reset
//   ram_ctrl  in   5   [4:2] funct3, [1] write, [0] access enable
//   ram_addr  in  32   byte address; bits above ADDR_W+1 are ignored (alias)
//   ram_din   in  32   store data, right-aligned
//   ram_dout  out 32   formatted load result, valid the cycle after a load
//   err       out  1   one-cycle pulse in the result cycle of a bad request
//   err_cnt   out 16   saturating count of bad requests
// -----------------------------------------------------------------------------
module cpu_dmem #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ram_ctrl,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_din,
    output logic [31:0] ram_dout,
    output logic        err,
    output logic [15:0] err_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic [2:0]        w_funct3;
    logic              w_en;
    logic              w_wr;
    logic              w_rd;
    logic [ADDR_W-1:0] w_word;
    logic [1:0]        w_off;
    logic              w_illegal;
    logic              w_mis_err;
    logic              w_err;
    logic              w_store_ok;
    logic [3:0]        w_size_mask;
    logic [31:0]       w_lane;
    logic              w_unused;

    // A request that arrives while rst is high is dropped completely.
    assign w_funct3 = ram_ctrl[4:2];
    assign w_en     = ram_ctrl[0] && !rst;
    assign w_wr     = w_en && ram_ctrl[1];
    assign w_rd     = w_en && !ram_ctrl[1];
    assign w_word   = ram_addr[ADDR_W+1:2];
    assign w_off    = ram_addr[1:0];

    // The upper address bits only alias the memory, so they are ignored.
    assign w_unused = ^ram_addr[31:ADDR_W+2];

    // Legal stores are SB/SH/SW (000..010).
    // Legal loads are LB/LH/LW/LBU/LHU (000,001,010,100,101).
    assign w_illegal = ram_ctrl[1] ? (w_funct3 > 3'd2)
                                   : ((w_funct3 == 3'd3) || (w_funct3[2:1] == 2'b11));

    // The low funct3 bits encode the access size for loads and stores alike.
    always_comb begin
        // NOTE: every always_comb target gets a default first, so no path can infer a latch.
        w_size_mask = 4'b0000;
        case (w_funct3[1:0])
            2'b00:   w_size_mask = 4'b0001;
            2'b01:   w_size_mask = 4'b0011;
            2'b10:   w_size_mask = 4'b1111;
            default: w_size_mask = 4'b0000;
        endcase
    end

`ifdef DMEM_MISALIGN_EN
    // Any alignment is served, so only an illegal funct3 is an error.
    assign w_mis_err = 1'b0;
`else
    // A halfword needs an even address; a word needs addr[1:0] == 00.
    assign w_mis_err = ((w_funct3[1:0] == 2'b01) && w_off[0]) ||
                       ((w_funct3[1:0] == 2'b10) && (w_off != 2'b00));
`endif

    assign w_err      = w_en && (w_illegal || w_mis_err);
    assign w_store_ok = w_wr && !w_illegal && !w_mis_err;

    // -------------------------------------------------------------------------
    // Load attributes and error tracking
    // -------------------------------------------------------------------------
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic        r_bad;
    logic        r_err;
    logic [15:0] r_err_cnt;

    // NOTE: sequential state is updated with non-blocking (<=) assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_funct3  <= 3'd0;
            r_off     <= 2'd0;
            r_bad     <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= 16'd0;
        end else begin
            // These capture only on loads, so stores and idle cycles leave
            // the formatted ram_dout unchanged.
            if (w_rd) begin
                r_funct3 <= w_funct3;
                r_off    <= w_off;
                r_bad    <= w_illegal || w_mis_err;
            end
            r_err <= w_err;
            if (w_err && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Storage
    // NOTE: the storage arrays are never reset; only the read registers next to them are, which is what clears ram_dout.
    // -------------------------------------------------------------------------
`ifdef DMEM_MISALIGN_EN
    localparam int HALF = DEPTH / 2;

    logic [31:0]       r_bank_even [HALF];
    logic [31:0]       r_bank_odd  [HALF];
    logic [ADDR_W-2:0] w_idx_even;
    logic [ADDR_W-2:0] w_idx_odd;
    logic [7:0]        w_be_win;
    logic [63:0]       w_wd_win;
    logic [3:0]        w_be_even;
    logic [3:0]        w_be_odd;
    logic [31:0]       w_wd_even;
    logic [31:0]       w_wd_odd;
    logic [31:0]       r_rd_even;
    logic [31:0]       r_rd_odd;
    logic              r_par;
    logic [63:0]       w_rd_win;

    // An access covers word w and word w+1, so both banks are always
    // touched. The odd bank holds w (w odd) or w+1 (w even); in both cases
    // its index is w>>1. The even bank holds w (w even) or w+1 (w odd).
    // Adding w[0] selects that row, and it wraps the top word onto word 0.
    assign w_idx_odd  = w_word[ADDR_W-1:1];
    assign w_idx_even = w_word[ADDR_W-1:1] + (ADDR_W-1)'(w_word[0]);

    // Place the access in a two-word window: low word = w, high word = w+1.
    assign w_be_win = {4'b0000, w_size_mask} << w_off;
    assign w_wd_win = {32'd0, ram_din} << {w_off, 3'b000};

    // Send each half of the window to the bank that holds that word.
    assign w_be_even = w_word[0] ? w_be_win[7:4]  : w_be_win[3:0];
    assign w_wd_even = w_word[0] ? w_wd_win[63:32] : w_wd_win[31:0];
    assign w_be_odd  = w_word[0] ? w_be_win[3:0]  : w_be_win[7:4];
    assign w_wd_odd  = w_word[0] ? w_wd_win[31:0]  : w_wd_win[63:32];

    always_ff @(posedge clk) begin
        if (w_store_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be_even[b]) r_bank_even[w_idx_even][8*b +: 8] <= w_wd_even[8*b +: 8];
                if (w_be_odd[b])  r_bank_odd[w_idx_odd][8*b +: 8]   <= w_wd_odd[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_even <= 32'd0;
            r_rd_odd  <= 32'd0;
            r_par     <= 1'b0;
        end else if (w_rd) begin
            r_rd_even <= r_bank_even[w_idx_even];
            r_rd_odd  <= r_bank_odd[w_idx_odd];
            r_par     <= w_word[0];
        end
    end

    // Rebuild the window as {word w+1, word w}, then shift the addressed byte
    // down to lane 0.
    assign w_rd_win = r_par ? {r_rd_even, r_rd_odd} : {r_rd_odd, r_rd_even};
    assign w_lane   = 32'(w_rd_win >> {r_off, 3'b000});
`else
    logic [31:0] r_mem [DEPTH];
    logic [3:0]  w_be;
    logic [31:0] w_wd;
    logic [31:0] r_rdata;

    // Accepted accesses are aligned, so shifting the size mask by the offset
    // stays inside one word.
    assign w_be = w_size_mask << w_off;
    assign w_wd = ram_din << {w_off, 3'b000};

    always_ff @(posedge clk) begin
        if (w_store_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_word][8*b +: 8] <= w_wd[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'd0;
        end else if (w_rd) begin
            r_rdata <= r_mem[w_word];
        end
    end

    assign w_lane = r_rdata >> {r_off, 3'b000};
`endif

    // -------------------------------------------------------------------------
    // Load formatting: lane shift (above), then extension.
    // A bad load, or an illegal funct3 hitting the default arm, gives 0.
    // -------------------------------------------------------------------------
    always_comb begin
        ram_dout = 32'd0;
        if (!r_bad) begin
            case (r_funct3)
                3'b000:  ram_dout = {{24{w_lane[7]}},  w_lane[7:0]};
                3'b001:  ram_dout = {{16{w_lane[15]}}, w_lane[15:0]};
                3'b010:  ram_dout = w_lane;
                3'b100:  ram_dout = {24'd0, w_lane[7:0]};
                3'b101:  ram_dout = {16'd0, w_lane[15:0]};
                default: ram_dout = 32'd0;
            endcase
        end
    end

    assign err     = r_err;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_cpu_dmem.sv
// -----------------------------------------------------------------------------
// tb_cpu_dmem -- self-checking bench for cpu_dmem.
//
// The reference model is a plain byte array addressed modulo the capacity.
// A store writes `size` consecutive bytes. A load gathers them and extends
// the result. Alignment is judged with address-modulo-size arithmetic.
// Directed scenarios compare against literal expected values. The random
// scenario compares every cycle against the model.
// -----------------------------------------------------------------------------
module tb_cpu_dmem;

    localparam int ADDR_W = 10;
    localparam int NBYTES = 4 << ADDR_W;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic        clk;
    logic        rst;
    logic [4:0]  ram_ctrl;
    logic [31:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic        err;
    logic [15:0] err_cnt;

    cpu_dmem #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .ram_ctrl (ram_ctrl),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state
    logic [7:0]  ref_mem [NBYTES];
    logic [31:0] exp_dout = 32'd0;
    logic        exp_err  = 1'b0;
    logic [15:0] exp_cnt  = 16'd0;

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    function automatic int acc_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit ref_illegal(input bit wr, input logic [2:0] f3);
        if (wr) return (f3 > 3'd2);
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        return (int'(addr[1:0]) % acc_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] v;
        logic [31:0] a;
        int          n;
        v = 32'd0;
        n = acc_size(f3);
        for (int k = 0; k < n; k++) begin
            a = addr + 32'(k);
            v[8*k +: 8] = ref_mem[a[ADDR_W+1:0]];
        end
        if (!f3[2]) begin
            if (n == 1)      v = {{24{v[7]}}, v[7:0]};
            else if (n == 2) v = {{16{v[15]}}, v[15:0]};
        end
        return v;
    endfunction

    // Drive one request for one cycle and update the model. Inputs change on
    // the falling edge. Outputs are ready to sample 1 time unit after the
    // next rising edge.
    task automatic issue(input bit en, input bit wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] din);
        bit          bad;
        logic [31:0] a;
        @(negedge clk);
        ram_ctrl = {f3, wr, en};
        ram_addr = en ? addr : 32'bz;
        ram_din  = din;
        exp_err  = 1'b0;
        if (rst) begin
            exp_dout = 32'd0;
            exp_cnt  = 16'd0;
        end else if (en) begin
            bad = ref_illegal(wr, f3);
`ifndef DMEM_MISALIGN_EN
            if (!bad) bad = ref_misaligned(f3, addr);
`endif
            exp_err = bad;
            if (bad && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            if (wr && !bad) begin
                for (int k = 0; k < acc_size(f3); k++) begin
                    a = addr + 32'(k);
                    ref_mem[a[ADDR_W+1:0]] = din[8*k +: 8];
                end
            end else if (!wr) begin
                exp_dout = bad ? 32'd0 : ref_load(f3, addr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        n_total++;
        if (ram_dout !== 32'd0) $display("FAIL reset_dout: got %h want 00000000", ram_dout);
        else n_pass++;
        n_total++;
        if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err);
        else n_pass++;
        n_total++;
        if (err_cnt !== 16'd0) $display("FAIL reset_cnt: got %h want 0000", err_cnt);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] want;
    } ld_vec_t;

    task automatic test_store_load();
        ld_vec_t v [7];
        v[0] = '{F_B,  32'h10, 32'h00000001};
        v[1] = '{F_BU, 32'h10, 32'h00000001};
        v[2] = '{F_H,  32'h10, 32'h00007F01};
        v[3] = '{F_HU, 32'h10, 32'h00007F01};
        v[4] = '{F_W,  32'h10, 32'h80FF7F01};
        v[5] = '{F_B,  32'h13, 32'hFFFFFF80};
        v[6] = '{F_HU, 32'h12, 32'h000080FF};
        issue(1'b1, 1'b1, F_W, 32'h10, 32'h80FF7F01);
        for (int i = 0; i < 7; i++) begin
            issue(1'b1, 1'b0, v[i].f3, v[i].addr, 32'd0);
            n_total++;
            if (ram_dout !== v[i].want)
                $display("FAIL store_load[%0d]: got %h want %h", i, ram_dout, v[i].want);
            else n_pass++;
            n_total++;
            if (err !== 1'b0) $display("FAIL store_load_err[%0d]: got %b want 0", i, err);
            else n_pass++;
        end
    endtask

    task automatic test_lane_mask();
        issue(1'b1, 1'b1, F_W, 32'h20, 32'hAABBCCDD);
        issue(1'b1, 1'b1, F_B, 32'h21, 32'hFFFFFF11);
        issue(1'b1, 1'b1, F_H, 32'h22, 32'hFFFF2233);
        issue(1'b1, 1'b0, F_W, 32'h20, 32'd0);
        n_total++;
        if (ram_dout !== 32'h223311DD) $display("FAIL lane_mask: got %h want 223311dd", ram_dout);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 1'b1, F_W, 32'h30, 32'd5);
        issue(1'b1, 1'b0, F_W, 32'h30, 32'd0);
        n_total++;
        if (ram_dout !== 32'd5) $display("FAIL b2b_load: got %h want 00000005", ram_dout);
        else n_pass++;
        idle();
        idle();
        issue(1'b1, 1'b1, F_W, 32'h34, 32'hDEADBEEF);
        idle();
        n_total++;
        if (ram_dout !== 32'd5) $display("FAIL b2b_hold: got %h want 00000005", ram_dout);
        else n_pass++;
    endtask

    task automatic test_errors();
        issue(1'b1, 1'b1, F_W, 32'h0, 32'h0BADF00D);
        issue(1'b1, 1'b0, 3'b011, 32'h30, 32'd0);
        n_total++;
        if (ram_dout !== 32'd0) $display("FAIL err_ld011_dout: got %h want 00000000", ram_dout);
        else n_pass++;
        n_total++;
        if (err !== 1'b1) $display("FAIL err_ld011_pulse: got %b want 1", err);
        else n_pass++;
        // Disabled SB with a floating address: no write, no error, no count.
        issue(1'b0, 1'b1, F_B, 32'h0, 32'h000000EE);
        n_total++;
        if (err !== 1'b0) $display("FAIL err_pulse_once: got %b want 0", err);
        else n_pass++;
        n_total++;
        if (err_cnt !== 16'd1) $display("FAIL err_cnt_one: got %h want 0001", err_cnt);
        else n_pass++;
        // Illegal store must not write.
        issue(1'b1, 1'b1, 3'b011, 32'h0, 32'hFFFFFFFF);
        n_total++;
        if (err !== 1'b1) $display("FAIL err_st011_pulse: got %b want 1", err);
        else n_pass++;
        issue(1'b1, 1'b0, F_W, 32'h0, 32'd0);
        n_total++;
        if (ram_dout !== 32'h0BADF00D) $display("FAIL err_no_write: got %h want 0badf00d", ram_dout);
        else n_pass++;
        n_total++;
        if (err_cnt !== 16'd2) $display("FAIL err_cnt_two: got %h want 0002", err_cnt);
        else n_pass++;
    endtask

    task automatic test_misalign();
        logic [31:0] want;
        logic        want_err;
`ifdef DMEM_MISALIGN_EN
        want     = 32'h55443322;
        want_err = 1'b0;
`else
        want     = 32'h00000000;
        want_err = 1'b1;
`endif
        issue(1'b1, 1'b1, F_W, 32'h10, 32'h44332211);
        issue(1'b1, 1'b1, F_W, 32'h14, 32'h88776655);
        issue(1'b1, 1'b0, F_W, 32'h11, 32'd0);
        n_total++;
        if (ram_dout !== want) $display("FAIL misalign_lw: got %h want %h", ram_dout, want);
        else n_pass++;
        n_total++;
        if (err !== want_err) $display("FAIL misalign_err: got %b want %b", err, want_err);
        else n_pass++;
        n_total++;
        if (err_cnt !== exp_cnt) $display("FAIL misalign_cnt: got %h want %h", err_cnt, exp_cnt);
        else n_pass++;
        // Misaligned halfword store across the word boundary, then read back
        // both words.
        issue(1'b1, 1'b1, F_H, 32'h13, 32'h0000BEEF);
        issue(1'b1, 1'b0, F_W, 32'h10, 32'd0);
        n_total++;
        if (ram_dout !== exp_dout) $display("FAIL misalign_sh_lo: got %h want %h", ram_dout, exp_dout);
        else n_pass++;
        issue(1'b1, 1'b0, F_W, 32'h14, 32'd0);
        n_total++;
        if (ram_dout !== exp_dout) $display("FAIL misalign_sh_hi: got %h want %h", ram_dout, exp_dout);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] top;
        logic [31:0] want_w;
        logic [31:0] want_h;
        logic        want_err;
        top = 32'(NBYTES);
`ifdef DMEM_MISALIGN_EN
        want_w   = 32'hB3B4A1A2;
        want_h   = 32'hFFFFB4A1;
        want_err = 1'b0;
`else
        want_w   = 32'h00000000;
        want_h   = 32'h00000000;
        want_err = 1'b1;
`endif
        issue(1'b1, 1'b1, F_W, top - 32'd4, 32'hA1A2A3A4);
        issue(1'b1, 1'b1, F_W, top, 32'hB1B2B3B4);
        issue(1'b1, 1'b0, F_W, top * 2, 32'd0);
        n_total++;
        if (ram_dout !== 32'hB1B2B3B4) $display("FAIL wrap_alias: got %h want b1b2b3b4", ram_dout);
        else n_pass++;
        issue(1'b1, 1'b0, F_W, top - 32'd2, 32'd0);
        n_total++;
        if (ram_dout !== want_w) $display("FAIL wrap_lw_top: got %h want %h", ram_dout, want_w);
        else n_pass++;
        n_total++;
        if (err !== want_err) $display("FAIL wrap_lw_err: got %b want %b", err, want_err);
        else n_pass++;
        issue(1'b1, 1'b0, F_H, top - 32'd1, 32'd0);
        n_total++;
        if (ram_dout !== want_h) $display("FAIL wrap_lh_top: got %h want %h", ram_dout, want_h);
        else n_pass++;
    endtask

    task automatic test_random();
        bit          en;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [2:0]  ld_ok [5];
        ld_ok[0] = F_B; ld_ok[1] = F_H; ld_ok[2] = F_W; ld_ok[3] = F_BU; ld_ok[4] = F_HU;
        // Fill the working region first, because memory contents start undefined.
        for (int i = 0; i < 64; i++) begin
            issue(1'b1, 1'b1, F_W, 32'h100 + 32'(4 * i), $urandom);
        end
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 9) != 0);
            wr = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (wr)                  f3 = 3'($urandom_range(0, 2));
            else                          f3 = ld_ok[$urandom_range(0, 4)];
            addr = 32'h100 + 32'($urandom_range(0, 248)) +
                   (32'($urandom_range(0, 7)) << (ADDR_W + 2));
            issue(en, wr, f3, addr, $urandom);
            n_total++;
            if (ram_dout !== exp_dout)
                $display("FAIL rand_dout[%0d]: got %h want %h", i, ram_dout, exp_dout);
            else n_pass++;
            n_total++;
            if (err !== exp_err)
                $display("FAIL rand_err[%0d]: got %b want %b", i, err, exp_err);
            else n_pass++;
            n_total++;
            if (err_cnt !== exp_cnt)
                $display("FAIL rand_cnt[%0d]: got %h want %h", i, err_cnt, exp_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 1'b1, F_W, 32'h40, 32'h12345678);
        issue(1'b1, 1'b0, F_W, 32'h40, 32'd0);
        n_total++;
        if (ram_dout !== 32'h12345678) $display("FAIL rstmid_pre: got %h want 12345678", ram_dout);
        else n_pass++;
        rst = 1'b1;
        issue(1'b1, 1'b0, F_W, 32'h40, 32'd0);
        n_total++;
        if (ram_dout !== 32'd0) $display("FAIL rstmid_dout: got %h want 00000000", ram_dout);
        else n_pass++;
        n_total++;
        if (err_cnt !== 16'd0) $display("FAIL rstmid_cnt: got %h want 0000", err_cnt);
        else n_pass++;
        // A store under reset must be dropped, and an illegal op must not count.
        issue(1'b1, 1'b1, F_W, 32'h40, 32'h0000DEAD);
        issue(1'b1, 1'b0, 3'b111, 32'h40, 32'd0);
        rst = 1'b0;
        idle();
        n_total++;
        if (err_cnt !== 16'd0) $display("FAIL rstmid_nocount: got %h want 0000", err_cnt);
        else n_pass++;
        issue(1'b1, 1'b0, F_W, 32'h40, 32'd0);
        n_total++;
        if (ram_dout !== 32'h12345678) $display("FAIL rstmid_retain: got %h want 12345678", ram_dout);
        else n_pass++;
    endtask

    // -------------------------------------------------------------------------
    // Sequence
    // -------------------------------------------------------------------------
    initial begin
        rst      = 1'b1;
        ram_ctrl = 5'd0;
        ram_addr = 32'd0;
        ram_din  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_store_load();
        test_lane_mask();
        test_back_to_back();
        test_errors();
        test_misalign();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cpu_dmem.md
# cpu_dmem

Data-memory responder on the core's load/store port. Each cycle it accepts at most one request (`ram_ctrl`, `ram_addr`, `ram_din`) from the memory-access stage. It performs byte, halfword or word stores with lane masking. It returns load data, already sign- or zero-extended, on `ram_dout` one cycle later, when the write-back stage samples it. It also flags and counts illegal or misaligned accesses.

## Interface
- `ADDR_W`, default 10: word-address width; capacity 2^ADDR_W words (default 4 KiB).
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ram_ctrl`  in  5  request control:
  - [4:2] funct3;
  - [1] write;
  - [0] access enable. The request is ignored entirely when [0]=0.
- `ram_addr`  in  32  byte address. Don't-care (may be Z) when ram_ctrl[0]=0. Bits above ADDR_W+1 are ignored, so the memory aliases.
- `ram_din`  in  32  store data. Right-aligned: byte/half stores use the low bits.
- `ram_dout`  out  32  load result, valid in the cycle after the load request.
- `err`  out  1  one-cycle pulse, aligned with the `ram_dout` cycle of an erroneous request.
- `err_cnt`  out  16  saturating count of erroneous requests.

## Operation
Request decode, sampled at rising edge N when ram_ctrl[0]=1:
- **Store** (ram_ctrl[1]=1). funct3 000=SB, 001=SH, 010=SW.
  - Byte lanes are selected by addr[1:0].
  - Unselected lanes keep their contents.
  - Memory is updated at edge N.
- **Load** (ram_ctrl[1]=0). funct3 000=LB, 001=LH, 010=LW, 100=LBU, 101=LHU.
  - The addressed word is read synchronously at edge N.
  - funct3 and addr[1:0] are registered alongside the read data.
  - Output formatting (lane shift, then sign/zero extension) is combinational from those registers.
- **Illegal funct3**: store funct3 ≥011, or load funct3 ∈ {011,110,111}.
  - No memory write.
  - A load returns 0.
  - Counts as an error.
- **Misaligned access**: halfword with addr[0]=1, or word with addr[1:0]≠00. Behaviour depends on the configuration (see Configuration).
- **Output hold**: `ram_dout` holds the last load result through cycles that follow stores or idle cycles. It is changed only by a new load.
- **Error handling**:
  - `err` goes high for exactly the cycle after the erroneous edge.
  - `err_cnt` increments at that same edge and saturates at 16'hFFFF.
- **Memory contents** are not reset and no initialisation is defined. The bench must write before it reads.

## Timing
- Load latency is 1 cycle. The request is present during cycle N-1 and sampled at edge N; `ram_dout` is valid from edge N until the next load edge.
- Store-to-load: a store at edge N followed by a load of the same address at edge N+1 returns the new data. No forwarding is needed because the write completes at edge N.
- Throughput is one request per cycle, back-to-back, with no stalls and no handshake. The block never back-pressures the core.
- Reset:
  - A request in a cycle with rst=1 is ignored: no write and no count.
  - Reset values: `ram_dout`=0, `err`=0, `err_cnt`=0, registered funct3/offset cleared.
  - Reset mid-load: the pending result is discarded and `ram_dout`=0 in the cycle after reset.
- Address wrap: byte address 2^(ADDR_W+2)+k accesses the same location as k.

## Configuration
- Macro `DMEM_MISALIGN_EN`.
- **Defined**:
  - Memory is split into even-word and odd-word banks, each 2^(ADDR_W-1) words.
  - Misaligned halfword and word accesses, including those crossing a word boundary, complete in a single cycle with the normal 1-cycle latency.
  - Byte lanes are assembled from both banks.
  - Crossing the top word wraps to word 0.
  - Misalignment is not an error.
- **Undefined**:
  - Single bank.
  - A misaligned access performs no write, and a misaligned load returns 0.
  - Each misaligned access pulses `err` and increments `err_cnt`.

## Test plan
- **Stores then loads.** Stimulus: SW 0x80FF7F01 @0x10; then LB, LBU, LH, LHU, LW @0x10 on consecutive cycles. Required `ram_dout`: 0x00000001, 0x00000001, 0x00007F01, 0x00007F01, 0x80FF7F01. Also required: LB @0x13 → 0xFFFFFF80; LHU @0x12 → 0x000080FF.
- **Lane masking.** Stimulus: SW 0xAABBCCDD @0x20; SB 0x11 @0x21; SH 0x2233 @0x22; LW @0x20. Required: 0x223311DD.
- **Back-to-back and hold.**
  - Stimulus: SW 5 @0x30, then immediately LW @0x30. Required: 5 on the next cycle.
  - Stimulus: idle cycles and a store to a different address. Required: `ram_dout` stays 5.
- **Errors.** Stimulus: load funct3=011, then SB with ram_ctrl[0]=0 and addr=Z.
  - Required for the funct3=011 load: `ram_dout`=0 and `err` pulses once.
  - Required for the disabled SB: no effect.
  - `err_cnt`=1.
- **Misalignment.** Stimulus: LW @0x11 after SW 0x44332211 @0x10 and SW 0x88776655 @0x14.
  - Without the macro: `ram_dout`=0, `err`=1, `err_cnt` increments.
  - With the macro: 0x55443322, no `err`.
- **Reset mid-stream.** Stimulus: LW issued in the same cycle rst=1. Required: `ram_dout`=0, `err_cnt`=0 afterwards. Memory written before the reset retains its value.
